// File: rtl/pipelined_ram_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_ram_pkg
//   Shared types, limits and helpers for pipelined_ram and its read pipe.
//   - ram_state_t      : controller state (CLEAR sweep, then READY)
//   - MAX_READ_LATENCY : deepest supported read pipeline
//   - MAX_WIDTH        : widest word the parity helper handles
//   - byte_parity()    : one even-parity bit per byte of a word
// ---------------------------------------------------------------------------
package pipelined_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram_state_t;

   localparam int MAX_READ_LATENCY = 4;
   localparam int MAX_WIDTH        = 256;

   // Callers zero-extend their word to MAX_WIDTH and keep the low WIDTH/8 bits.
   function automatic logic [MAX_WIDTH/8-1:0] byte_parity(input logic [MAX_WIDTH-1:0] data);
      logic [MAX_WIDTH/8-1:0] p;
      p = '0;
      for (int i = 0; i < MAX_WIDTH/8; i++) begin
         p[i] = ^data[8*i +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/pipelined_ram_rd_pipe.sv
// ---------------------------------------------------------------------------
// ram_rd_pipe
//   LATENCY-deep shift register carrying {valid, data, err} for read
//   responses. Data/err stages only load when their incoming valid is set,
//   so the output word holds the last response while out_valid is low.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     in_valid/data/err   : read sampled at the accept edge
//     out_valid/data/err  : response LATENCY cycles after accept
// ---------------------------------------------------------------------------
module ram_rd_pipe #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_err,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
);

   logic             vld_q  [LATENCY];
   logic [WIDTH-1:0] data_q [LATENCY];
   logic             err_q  [LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            vld_q[i]  <= 1'b0;
            data_q[i] <= '0;
            err_q[i]  <= 1'b0;
         end
      end else begin
         vld_q[0] <= in_valid;
         if (in_valid) begin
            data_q[0] <= in_data;
            err_q[0]  <= in_err;
         end
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               data_q[i] <= data_q[i-1];
               err_q[i]  <= err_q[i-1];
            end
         end
      end
   end

   assign out_valid = vld_q[LATENCY-1];
   assign out_data  = data_q[LATENCY-1];
   // Error is qualified so it only ever shows alongside a response.
   assign out_err   = vld_q[LATENCY-1] & err_q[LATENCY-1];

endmodule

// File: rtl/pipelined_ram.sv
// ---------------------------------------------------------------------------
// pipelined_ram
//   Single-port synchronous RAM with a valid/ready request port, per-byte
//   write enables, READ_LATENCY-cycle read responses and a clear sweep that
//   writes INIT_VALUE to every word after reset.
//   Optional feature macro: PIPELINED_RAM_PARITY_EN (per-byte even parity,
//   rsp_err on mismatch, debug task parity_flip).
//   Ports:
//     clk, reset                    : clock, synchronous active-high reset
//     req_valid/req_ready           : request handshake
//     req_write/addr/wdata/be       : request payload
//     rsp_valid/rsp_rdata/rsp_err   : read response (no backpressure)
//     init_done                     : clear sweep finished
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1 (and reset is low). req_ready depends only on the
//   controller state, never on req_valid. Responses are pushed without
//   backpressure; the consumer must take every rsp_valid pulse.
// ---------------------------------------------------------------------------
module pipelined_ram
   import pipelined_ram_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               ADDR_W       = 4,
   parameter int               READ_LATENCY = 1,
   parameter logic [WIDTH-1:0] INIT_VALUE   = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [WIDTH-1:0]     req_wdata,
   input  logic [WIDTH/8-1:0]   req_be,
   output logic                 rsp_valid,
   output logic [WIDTH-1:0]     rsp_rdata,
   output logic                 rsp_err,
   output logic                 init_done
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = WIDTH/8;
   // Out-of-range latencies are clamped into 1..MAX_READ_LATENCY.
   localparam int LAT   = (READ_LATENCY < 1) ? 1 :
                          (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

   logic [WIDTH-1:0]  mem [DEPTH];
   ram_state_t        state;
   logic [ADDR_W-1:0] clr_cnt;

   logic             accept, wr_fire, rd_fire;
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] rd_data;
   logic             rd_err;

   assign req_ready = (state == READY);
   assign init_done = (state == READY);
   assign accept    = req_valid & req_ready & ~reset;
   assign wr_fire   = accept & req_write;
   assign rd_fire   = accept & ~req_write;
   assign rd_data   = mem[req_addr];

   // Controller: CLEAR sweeps every address once, then parks in READY.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == ADDR_W'(DEPTH-1)) state <= READY;
            end
            default: state <= READY;
         endcase
      end
   end

   // Post-merge word for a write: enabled bytes from wdata, others kept.
   always_comb begin
      merged = mem[req_addr];
      for (int b = 0; b < NB; b++) begin
         if (req_be[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR)  mem[clr_cnt]  <= INIT_VALUE;
         else if (wr_fire)    mem[req_addr] <= merged;
      end
   end

`ifdef PIPELINED_RAM_PARITY_EN
   logic [NB-1:0]          par [DEPTH];
   logic [MAX_WIDTH/8-1:0] par_wr_full, par_rd_full;

   assign par_wr_full = byte_parity(MAX_WIDTH'((state == CLEAR) ? INIT_VALUE : merged));
   assign par_rd_full = byte_parity(MAX_WIDTH'(rd_data));
   assign rd_err      = (par[req_addr] != par_rd_full[NB-1:0]);

   // Plain always so the debug task below may also poke the array.
   always @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR)  par[clr_cnt]  <= par_wr_full[NB-1:0];
         else if (wr_fire)    par[req_addr] <= par_wr_full[NB-1:0];
      end
   end

   // Debug only: corrupt one stored parity bit to exercise rsp_err.
   task parity_flip(input logic [ADDR_W-1:0] addr, input int byte_idx);
      par[addr][byte_idx] = ~par[addr][byte_idx];
   endtask
`else
   assign rd_err = 1'b0;
`endif

   ram_rd_pipe #(
      .WIDTH   (WIDTH),
      .LATENCY (LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rd_fire),
      .in_data   (rd_data),
      .in_err    (rd_err),
      .out_valid (rsp_valid),
      .out_data  (rsp_rdata),
      .out_err   (rsp_err)
   );

endmodule

// File: tb/tb_pipelined_ram.sv
// ---------------------------------------------------------------------------
// tb_pipelined_ram
//   Directed and random stimulus for pipelined_ram (16 x 32, read latency 2)
//   checked every cycle against a behavioural memory model with a queue of
//   expected read responses and their due cycles.
// ---------------------------------------------------------------------------
module tb_pipelined_ram;

   localparam int W     = 32;
   localparam int AW    = 4;
   localparam int LAT   = 2;
   localparam int DEPTH = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset     = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [W-1:0]  req_wdata = '0;
   logic [3:0]    req_be    = '0;
   logic          req_ready, rsp_valid, rsp_err, init_done;
   logic [W-1:0]  rsp_rdata;

   pipelined_ram #(
      .WIDTH        (W),
      .ADDR_W       (AW),
      .READ_LATENCY (LAT),
      .INIT_VALUE   (32'h0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .init_done (init_done)
   );

   // ---------------- reference model ----------------
   logic [W-1:0] model_mem [DEPTH];
   logic         perr      [DEPTH];
   int           clr_left = DEPTH;
   int           cyc      = 0;
   logic [W-1:0] last_rdata = '0;
   logic [W-1:0] exp_q [$];
   logic         err_q [$];
   int           due_q [$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply the request/reset seen at this rising edge to the model.
   task automatic model_edge();
      logic [W-1:0] mask;
      if (reset) begin
         clr_left   = DEPTH;
         last_rdata = '0;
         exp_q.delete();
         err_q.delete();
         due_q.delete();
      end else if (clr_left > 0) begin
         model_mem[DEPTH - clr_left] = 32'h0;
         perr[DEPTH - clr_left]      = 1'b0;
         clr_left--;
      end else if (req_valid) begin
         if (req_write) begin
            mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
            model_mem[req_addr] = (model_mem[req_addr] & ~mask) | (req_wdata & mask);
            perr[req_addr]      = 1'b0;
         end else begin
            exp_q.push_back(model_mem[req_addr]);
            err_q.push_back(perr[req_addr]);
            due_q.push_back(cyc + 1 + LAT - 1);
         end
      end
   endtask

   task automatic check_outputs();
      logic exp_v;
      logic [W-1:0] d;
      logic e;
      check("req_ready", req_ready, clr_left == 0);
      check("init_done", init_done, clr_left == 0);
      exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
         d = exp_q.pop_front();
         e = err_q.pop_front();
         void'(due_q.pop_front());
         last_rdata = d;
         check("rsp_rdata", rsp_rdata, d);
         check("rsp_err", rsp_err, e);
      end else begin
         check("rsp_rdata_hold", rsp_rdata, last_rdata);
         check("rsp_err_idle", rsp_err, 1'b0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] be);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = be;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_clear();
      int n;
      n = 0;
      for (int i = 0; i < 40 && req_ready !== 1'b1; i++) begin
         n++;
         tick();
      end
      check("clear_cycles", n, DEPTH);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = 32'hFFFF_FFFF;
         perr[i]      = 1'b0;
      end

      // Reset for two cycles; all outputs must be at reset values.
      reset = 1'b1;
      tick();
      tick();
      check("reset_rsp_rdata", rsp_rdata, 32'h0);
      reset = 1'b0;
      wait_clear();

      // Every location reads back as the clear value, back to back.
      for (int a = 0; a < DEPTH; a++) begin
         req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(a);
         tick();
      end
      idle(4);

      // Full-word writes then consecutive reads.
      do_write(4'd2, 32'h0000_AAAA, 4'hF);
      do_write(4'd3, 32'h0000_BBBB, 4'hF);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd2; tick();
      req_addr  = 4'd3; tick();
      idle(4);

      // Byte-enable merge.
      do_write(4'd5, 32'h1122_3344, 4'hF);
      do_write(4'd5, 32'hAABB_CCDD, 4'b0101);
      do_read(4'd5);
      idle(3);
      check("be_merge_model", model_mem[5], 32'h11BB_33DD);

      // Write immediately followed by a read of the same address.
      do_write(4'd7, 32'hDEAD_BEEF, 4'hF);
      do_read(4'd7);
      // Read-shaped inputs with req_valid low: no response.
      req_valid = 1'b0; req_write = 1'b0; req_addr = 4'd7;
      for (int i = 0; i < 4; i++) tick();
      // Zero byte enables: no-op write.
      do_write(4'd5, 32'h0000_0000, 4'h0);
      do_read(4'd5);
      idle(3);

      // Reset the cycle after a read accept: response is dropped.
      do_read(4'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_clear();
      do_read(4'd2);
      idle(3);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         req_valid = 1'($urandom_range(0, 3) != 0);
         req_write = 1'($urandom_range(0, 1));
         req_addr  = AW'($urandom_range(0, DEPTH-1));
         req_wdata = $urandom;
         req_be    = 4'($urandom_range(0, 15));
         tick();
      end
      idle(4);

`ifdef PIPELINED_RAM_PARITY_EN
      do_write(4'd9, 32'h0102_0304, 4'hF);
      dut.parity_flip(4'd9, 1);
      perr[9] = 1'b1;
      do_read(4'd9);
      do_read(4'd8);
      idle(4);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
